// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, decode field
// positions and default widths.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 32;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned ALUOP_MSB = 6;
    localparam int unsigned ALUOP_LSB = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL,
        DISCARD
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset to RESET_PC, jump load has priority over +1 increment
// (wraps modulo 2^ADDR_W).
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned         ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, single-entry output
// holding register, jump redirect. FETCH_PERF_CNT_EN adds a handshake counter.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned         ADDR_W   = ADDR_W_DEF,
    parameter int unsigned         DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]   RESET_PC = 12'd0
) (
    input  logic              clk,
    input  logic              clr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [4:0]        OP,
    output logic [4:0]        ALUOP
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc;
    logic              capture;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .clr       (clr),
        .load      (jump_en),
        .load_addr (jump_target),
        .inc       (capture),
        .pc        (pc)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A jump with a request still in flight must swallow the stale response.
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (jump_en) begin
                    state_d = imem_valid ? REQ : DISCARD;
                end else if (imem_valid) begin
                    capture = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                if (jump_en || out_ready) begin
                    state_d = REQ;
                end
            end
            DISCARD: begin
                if (imem_valid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            instr  <= '0;
            pc_out <= '0;
        end else if (capture) begin
            instr  <= imem_rdata;
            pc_out <= pc;
        end
    end

    assign OP    = instr[OP_MSB:OP_LSB];
    assign ALUOP = instr[ALUOP_MSB:ALUOP_LSB];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            fetch_count <= '0;
        end else if (out_valid && out_ready) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the PC and instruction-memory address width in words.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction width.
REQ-003 Parameter RESET_PC, default 12'd0, SHALL set the PC value loaded on reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 clr  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 imem_req  output  1 / imem_addr  output  ADDR_W  SHALL form the fetch request; imem_addr is valid while imem_req=1.
REQ-007 imem_valid  input  1 / imem_rdata  input  DATA_W  SHALL return one instruction per request, at least 1 cycle after the request.
REQ-008 jump_en  input  1 / jump_target  input  ADDR_W  SHALL redirect fetch.
REQ-009 out_valid  output  1 / out_ready  input  1  SHALL form the valid/ready handshake to the decoder.
REQ-010 instr  output  DATA_W / pc_out  output  ADDR_W  SHALL carry the held instruction and its fetch address.
REQ-011 OP  output  5 = instr[31:27], ALUOP  output  5 = instr[6:2]  SHALL feed the downstream add/ALU decode directly.

Function
REQ-012 FSM states SHALL be IDLE, REQ, FULL and DISCARD.
REQ-013 IDLE SHALL go to REQ on the first clock after reset release.
REQ-014 In REQ, the block SHALL hold imem_req=1 and imem_addr=pc until imem_valid.
REQ-015 On imem_valid in REQ, the block SHALL capture instr<=imem_rdata and pc_out<=pc, set pc<=pc+1 (mod 2^ADDR_W, so 4095 wraps to 0), and go to FULL.
REQ-016 In FULL, out_valid SHALL be 1, and instr, pc_out, OP and ALUOP SHALL stay stable until out_ready=1.
REQ-017 On out_valid&&out_ready, the block SHALL go to REQ, with out_valid=0 the next cycle; latency from request to out_valid is exactly 1 cycle after imem_valid.
REQ-018 jump_en SHALL take priority over every other event: pc<=jump_target and out_valid<=0 on the next cycle.
REQ-019 On jump_en with a request outstanding (REQ without imem_valid in the same cycle), the block SHALL go to DISCARD, drop the next imem_valid response, then go to REQ.
REQ-020 On jump_en coincident with imem_valid in REQ, the response SHALL be dropped and the FSM SHALL go to REQ.
REQ-021 On jump_en in FULL or IDLE, the held instruction SHALL be dropped and the FSM SHALL go to REQ.
REQ-022 imem_req SHALL be 0 in FULL, DISCARD and IDLE.

Reset
REQ-023 While clr=0, outputs SHALL be: pc=RESET_PC, state=IDLE, out_valid=0, imem_req=0, instr=0, pc_out=0 (so OP=0 and ALUOP=0).
REQ-024 Reset asserted mid-fetch SHALL abandon the outstanding request; the first response after release SHALL be for RESET_PC.

Configuration
REQ-025 With FETCH_PERF_CNT_EN defined, the block SHALL add output fetch_count[15:0].
REQ-026 fetch_count SHALL increment on each out_valid&&out_ready handshake, wrap at 0xFFFF to 0, and reset to 0.
REQ-027 Without FETCH_PERF_CNT_EN, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-028 A shared package fetch_pkg SHALL hold the FSM state enum, OP/ALUOP bit-position constants (31:27, 6:2) and the ADDR_W/DATA_W defaults.
REQ-029 The PC register with +1 adder and jump load SHALL be one sub-module, fetch_pc_reg.

Verification
REQ-030 Release reset, imem_valid 2 cycles after each req, out_ready=1 -> imem_addr sequence 0,1,2,3, and pc_out matches each instr.
REQ-031 imem_rdata=32'h0000_0000 -> OP=5'b00000 and ALUOP=5'b00000 while out_valid=1.
REQ-032 Hold out_ready=0 for 5 cycles in FULL -> instr stable, imem_req=0, out_valid=1 throughout.
REQ-033 jump_en with jump_target=12'h100 during an outstanding request -> the stale response is dropped, the next imem_addr is 12'h100, and pc_out=12'h100.
REQ-034 Set pc to 12'hFFF (via jump) and fetch -> the next imem_addr is 12'h000.
REQ-035 Assert clr=0 while imem_req=1 -> out_valid=0 immediately, and the first request after release is at RESET_PC; with FETCH_PERF_CNT_EN, fetch_count=0.
